// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Resolves load-use stalls, ID-stage branch/jump flushes and multi-cycle data-memory
// accesses (with timeout and sticky error), and keeps saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_branch_taken,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memsig,
    input  logic             mem_ack,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic             pc_wr_en,
    output logic             pc_sel_br,
    output logic             ifid_wr_en,
    output logic             ifid_flush,
    output logic             idex_wr_en,
    output logic             idex_bubble,
    output logic             exmem_wr_en,
    output logic             memwb_bubble,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    state_t          state;
    logic [TO_W-1:0] tmo_cnt;

    logic uses_rs;
    logic uses_rt;
    logic is_br_op;
    logic hold;
    logic lu_haz;
    logic br;
    logic timeout;

    // Decode which source registers the ID instruction reads and whether it can redirect the PC.
    always_comb begin
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        is_br_op = 1'b0;
        case (id_opcode)
            4'b1111, 4'b1000, 4'b1001, 4'b1011, 4'b1101: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            4'b1010, 4'b1100: begin
                uses_rs = 1'b1;
            end
            4'b0101, 4'b0100, 4'b0110: begin
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                is_br_op = 1'b1;
            end
            4'b0001: begin
                is_br_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Hazard detection; register 0 is deliberately compared like any other register.
    assign hold    = ((state == RUN) && mem_memsig) || (state == MEM_WAIT);
    assign lu_haz  = ex_memrd && ((uses_rs && (id_rs == ex_rd)) || (uses_rt && (id_rt == ex_rd)));
    assign br      = id_branch_taken && is_br_op;
    assign timeout = (state == MEM_WAIT) && !mem_ack && (tmo_cnt == TO_LAST);
    assign mem_req = (state == MEM_WAIT);

    // Stage controls with priority hold > load-use > branch; frozen stages mask the lower ones.
    always_comb begin
        pc_wr_en     = 1'b1;
        pc_sel_br    = 1'b0;
        ifid_wr_en   = 1'b1;
        ifid_flush   = 1'b0;
        idex_wr_en   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_wr_en  = 1'b1;
        memwb_bubble = 1'b0;
        if (hold) begin
            pc_wr_en     = 1'b0;
            ifid_wr_en   = 1'b0;
            idex_wr_en   = 1'b0;
            exmem_wr_en  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (lu_haz) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_bubble = 1'b1;
        end else if (br) begin
            pc_sel_br  = 1'b1;
            ifid_flush = 1'b1;
        end
    end

    // Memory-access FSM with timeout counter and sticky error (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            tmo_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_memsig) begin
                        state   <= MEM_WAIT;
                        tmo_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    tmo_cnt <= tmo_cnt + TO_W'(1);
                    if (mem_ack || timeout) begin
                        state <= RELEASE;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
            if (timeout) begin
                mem_err <= 1'b1;
            end else if (err_clr) begin
                mem_err <= 1'b0;
            end
        end
    end

    // Saturating performance counters; a clear request overrides the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_wr_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector bench for pipe_hazard_ctrl (CNT_W=4 to reach saturation).
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 15;

    // Packed control vector order:
    // {pc_wr_en, pc_sel_br, ifid_wr_en, ifid_flush, idex_wr_en, idex_bubble, exmem_wr_en, memwb_bubble, mem_req}
    localparam logic [8:0] V_IDLE  = 9'b101010100;
    localparam logic [8:0] V_LU    = 9'b000011100;
    localparam logic [8:0] V_BR    = 9'b111110100;
    localparam logic [8:0] V_HOLD  = 9'b000000010;
    localparam logic [8:0] V_WAIT  = 9'b000000011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       id_opcode;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_branch_taken, ex_memrd, mem_memsig, mem_ack, err_clr, cnt_clr;
    logic             pc_wr_en, pc_sel_br, ifid_wr_en, ifid_flush, idex_wr_en, idex_bubble;
    logic             exmem_wr_en, memwb_bubble, mem_req, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [8:0]       ctl;

    int tests_run = 0;
    int tests_failed = 0;
    int n;

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_branch_taken(id_branch_taken), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
        .mem_memsig(mem_memsig), .mem_ack(mem_ack), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .pc_wr_en(pc_wr_en), .pc_sel_br(pc_sel_br), .ifid_wr_en(ifid_wr_en),
        .ifid_flush(ifid_flush), .idex_wr_en(idex_wr_en), .idex_bubble(idex_bubble),
        .exmem_wr_en(exmem_wr_en), .memwb_bubble(memwb_bubble), .mem_req(mem_req),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_wr_en, pc_sel_br, ifid_wr_en, ifid_flush, idex_wr_en,
                  idex_bubble, exmem_wr_en, memwb_bubble, mem_req};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle well before the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_opcode = 4'b0000; id_rs = '0; id_rt = '0; id_branch_taken = 1'b0;
        ex_memrd = 1'b0; ex_rd = '0; mem_memsig = 1'b0; mem_ack = 1'b0;
        err_clr = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("reset_ctl", 32'(ctl), 32'(V_IDLE));
        check("reset_err", 32'(mem_err), 32'd0);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_flush", 32'(flush_count), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_ctl", 32'(ctl), 32'(V_IDLE));

        // Load-use: lw to r3 in EX, ID reads r3 as rt
        ex_memrd = 1'b1; ex_rd = 4'd3; id_opcode = 4'b1000; id_rs = 4'd0; id_rt = 4'd3;
        #1 check("lu_stall", 32'(ctl), 32'(V_LU));
        step();
        ex_memrd = 1'b0;
        #1 check("lu_after", 32'(ctl), 32'(V_IDLE));
        check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        // rt match on an rs-only opcode is not a hazard
        ex_memrd = 1'b1; ex_rd = 4'd7; id_opcode = 4'b1010; id_rs = 4'd1; id_rt = 4'd7;
        #1 check("rs_only_no_haz", 32'(ctl), 32'(V_IDLE));
        // Register 0 still participates in hazard checks
        ex_rd = 4'd0; id_opcode = 4'b1111; id_rs = 4'd0; id_rt = 4'd9;
        #1 check("r0_haz", 32'(ctl), 32'(V_LU));
        idle_inputs();
        clear_counters();
        check("cnt_clr_stall", 32'(stall_cycles), 32'd0);

        // Taken beq without hazard
        id_opcode = 4'b0101; id_rs = 4'd1; id_rt = 4'd2; id_branch_taken = 1'b1;
        #1 check("beq_flush", 32'(ctl), 32'(V_BR));
        step();
        id_branch_taken = 1'b0;
        #1 check("beq_after", 32'(ctl), 32'(V_IDLE));
        check("beq_flush_cnt", 32'(flush_count), 32'd1);

        // Jump whose rs field matches a load destination: flush, no stall
        id_opcode = 4'b0001; id_rs = 4'd2; ex_rd = 4'd2; ex_memrd = 1'b1; id_branch_taken = 1'b1;
        #1 check("jump_flush", 32'(ctl), 32'(V_BR));
        step();
        idle_inputs();
        #1 check("jump_flush_cnt", 32'(flush_count), 32'd2);
        check("jump_no_stall", 32'(stall_cycles), 32'd0);

        // Taken branch on a non-branch opcode does nothing
        id_opcode = 4'b1001; id_branch_taken = 1'b1;
        #1 check("nonbr_taken", 32'(ctl), 32'(V_IDLE));

        // Load-use and taken branch together: stall first, flush next cycle
        ex_memrd = 1'b1; ex_rd = 4'd5; id_opcode = 4'b0101; id_rs = 4'd5; id_rt = 4'd6;
        id_branch_taken = 1'b1;
        #1 check("sim_c1", 32'(ctl), 32'(V_LU));
        step();
        ex_memrd = 1'b0;
        #1 check("sim_c2", 32'(ctl), 32'(V_BR));
        step();
        idle_inputs();
        #1 check("sim_stall_cnt", 32'(stall_cycles), 32'd1);
        check("sim_flush_cnt", 32'(flush_count), 32'd3);

        // mem_ack outside MEM_WAIT is ignored
        mem_ack = 1'b1;
        #1 check("ack_ignored", 32'(ctl), 32'(V_IDLE));
        step();
        mem_ack = 1'b0;
        #1 check("ack_ignored2", 32'(ctl), 32'(V_IDLE));
        clear_counters();

        // Memory access, ack on the third MEM_WAIT cycle; concurrent branch is masked
        mem_memsig = 1'b1; id_opcode = 4'b0101; id_branch_taken = 1'b1;
        #1 check("mem_hold_run", 32'(ctl), 32'(V_HOLD));
        step();
        #1 check("mem_wait1", 32'(ctl), 32'(V_WAIT));
        step();
        #1 check("mem_wait2", 32'(ctl), 32'(V_WAIT));
        step();
        mem_ack = 1'b1;
        #1 check("mem_wait3", 32'(ctl), 32'(V_WAIT));
        step();
        mem_ack = 1'b0; id_branch_taken = 1'b0;
        #1 check("mem_release", 32'(ctl), 32'(V_IDLE));
        step();
        mem_memsig = 1'b0;
        #1 check("mem_back_run", 32'(ctl), 32'(V_IDLE));
        check("mem_stall_cnt", 32'(stall_cycles), 32'd4);
        check("mem_no_err", 32'(mem_err), 32'd0);
        idle_inputs();
        clear_counters();

        // Timeout: no ack
        mem_memsig = 1'b1;
        step();
        mem_memsig = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        check("tmo_req_cycles", 32'(n), 32'd15);
        check("tmo_err_set", 32'(mem_err), 32'd1);
        check("tmo_release", 32'(ctl), 32'(V_IDLE));
        check("stall_saturate", 32'(stall_cycles), 32'd15);
        step();
        step();
        check("tmo_err_sticky", 32'(mem_err), 32'd1);
        check("stall_sat_hold", 32'(stall_cycles), 32'd15);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1 check("tmo_err_clr", 32'(mem_err), 32'd0);

        // Asynchronous reset in the middle of MEM_WAIT
        mem_memsig = 1'b1;
        step();
        mem_memsig = 1'b0;
        step();
        check("rst_pre_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_ctl", 32'(ctl), 32'(V_IDLE));
        check("rst_mid_err", 32'(mem_err), 32'd0);
        check("rst_mid_stall", 32'(stall_cycles), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_after_ctl", 32'(ctl), 32'(V_IDLE));
        check("rst_after_err", 32'(mem_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB) driven by the 4-bit opcode decoder.
- Generates per-stage write-enables, bubbles and flushes for load-use stalls, taken branches/jumps resolved in ID, and multi-cycle data-memory accesses.
- Owns the data-memory req/ack handshake, including a timeout with a sticky error flag.
- Keeps saturating performance counters for stall cycles and flushes.

Parameters:
REG_W, 4, register-specifier width
CNT_W, 16, performance counter width
MEM_TIMEOUT, 15, max MEM_WAIT cycles without ack before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_opcode  in  4  opcode of instruction in ID
id_rs  in  REG_W  source register 1 in ID
id_rt  in  REG_W  source register 2 in ID
id_branch_taken  in  1  ID comparator result (branch condition true, or jump)
ex_memrd  in  1  EX-stage instruction is a load (MemRd)
ex_rd  in  REG_W  EX-stage destination register
mem_memsig  in  1  MEM-stage instruction accesses memory (MEMSig)
mem_ack  in  1  memory access complete pulse
err_clr  in  1  synchronous clear of mem_err
cnt_clr  in  1  synchronous clear of both counters
pc_wr_en  out  1  PC update enable
pc_sel_br  out  1  PC takes branch/jump target
ifid_wr_en  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID cleared to NOP
idex_wr_en  out  1  ID/EX write enable
idex_bubble  out  1  ID/EX loaded with all-zero control
exmem_wr_en  out  1  EX/MEM write enable
memwb_bubble  out  1  MEM/WB loaded with all-zero control
mem_req  out  1  data-memory request
mem_err  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_wr_en=0
flush_count  out  CNT_W  saturating count of ifid_flush cycles

Behaviour:
- FSM states RUN, MEM_WAIT, RELEASE. Reset: state=RUN, timeout counter=0, mem_err=0, counters=0.
- hold = (RUN & mem_memsig) | MEM_WAIT. RELEASE never asserts hold.
- Register usage:
  - uses_rs: opcodes 1111,1000,1001,1010,1011,1100,1101,0101,0100,0110.
  - uses_rt: 1111,1000,1001,1011,1101,0101,0100,0110.
  - 0001 (jump) and undefined opcodes use neither.
- Register 0 is not exempt from hazard checks.
- lu_haz = ex_memrd & ((uses_rs & id_rs==ex_rd) | (uses_rt & id_rt==ex_rd)).
- br = id_branch_taken & opcode in {0101,0100,0110,0001}.
- Priority: hold > lu_haz > br. Outputs are combinational from state and inputs.
  - hold: pc_wr_en=ifid_wr_en=idex_wr_en=exmem_wr_en=0, memwb_bubble=1, all others 0. lu_haz and br are ignored because their stages are frozen.
  - lu_haz (no hold): pc_wr_en=ifid_wr_en=0, idex_bubble=1, idex_wr_en=1, exmem_wr_en=1. Exactly one bubble, since the next cycle ex_memrd belongs to the bubble. br is suppressed and re-evaluated next cycle.
  - br (no hold, no lu_haz): pc_sel_br=1, ifid_flush=1, pc_wr_en=1, all enables 1. Single flush cycle.
  - Otherwise: all enables=1, all bubbles/flushes/pc_sel_br=0.
- Values with inputs idle after reset: pc_wr_en=ifid_wr_en=idex_wr_en=exmem_wr_en=1; all other outputs 0.
- Transitions:
  - RUN & mem_memsig -> MEM_WAIT.
  - MEM_WAIT & mem_ack -> RELEASE.
  - MEM_WAIT & timeout counter == MEM_TIMEOUT-1 & !mem_ack -> RELEASE, and mem_err set.
  - RELEASE -> RUN unconditionally. This guarantees the completed access advances without re-request.
- mem_req=1 exactly while in MEM_WAIT. mem_ack outside MEM_WAIT is ignored.
- Minimum memory access: ack on the first MEM_WAIT cycle gives 2 hold cycles.
- Timeout counter: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle.
- mem_err: set on timeout, cleared by err_clr. Set wins if both occur in the same cycle.
- Counters:
  - stall_cycles increments when pc_wr_en=0; flush_count increments when ifid_flush=1.
  - Both saturate at all-ones. cnt_clr wins over increment.
- Reset mid-MEM_WAIT: mem_req drops immediately (asynchronously), state=RUN, no error is recorded.

Test Plan:
- Load-use: EX lw ex_rd=3, ID opcode 1000 id_rt=3 -> one cycle pc_wr_en=0, idex_bubble=1; next cycle normal; stall_cycles=1.
- Taken beq, no hazard -> one cycle pc_sel_br=1, ifid_flush=1; flush_count=1. Jump 0001 with id_rs matching ex_rd -> flush without stall.
- Simultaneous: EX load ex_rd=5, ID beq id_rs=5, taken -> cycle 1 stall only (no flush); cycle 2 (ex_memrd=0) flush.
- Memory: mem_memsig=1, ack 3 cycles after mem_req rises -> hold for 4 cycles, mem_req high 3 cycles, RELEASE cycle with all enables 1, stall_cycles=4.
- Timeout: no ack -> mem_req high exactly 15 cycles, mem_err=1 until err_clr pulse; stall count saturation with CNT_W=4 holds at 15.
- Assert rst_n=0 during MEM_WAIT -> mem_req=0 immediately, all outputs at reset values, mem_err=0.
